// File: rtl/core_pkg.sv
// Shared L1 cache constants and types used by the tag-store write controller.
package core_pkg;

    localparam int L1_SETS    = 256;
    localparam int L1_IDX_W   = 8;
    localparam int L1_ENTRY_W = 19;

    // One tag-store entry: valid flag on top of the tag.
    typedef struct packed {
        logic                  valid;
        logic [L1_ENTRY_W-2:0] tag;
    } l1_tag_entry_t;

    typedef enum logic {
        TW_INIT = 1'b0,
        TW_RUN  = 1'b1
    } tag_wr_state_t;

endpackage

// File: rtl/l1_tag_writer.sv
// Write-port controller for the L1 tag SRAM: initial invalidate sweep,
// fill/invalidate requests, and same-set read/write bypass.
//
// Handshake: a request transfers on a rising edge where wr_valid and wr_ready
// are both high; wr_valid may be raised at any time and the request fields must
// be stable while wr_valid is high; wr_ready never depends on wr_valid.
module l1_tag_writer
    import core_pkg::*;
#(
    parameter int ENTRY_W = L1_ENTRY_W,
    parameter int SETS    = L1_SETS,
    parameter int IDX_W   = L1_IDX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [ENTRY_W-2:0] wr_tag,
    input  logic               wr_inv,
    input  logic               rd_en,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic               sram_csb0,
    output logic [IDX_W-1:0]   sram_addr0,
    output logic [ENTRY_W-1:0] sram_din0,
    output logic               init_done,
    output logic               byp_valid,
    output logic [ENTRY_W-1:0] byp_data,
    output tag_wr_state_t      dbg_state
);

    // One extra bit so comparing against SETS-1 never aliases after wrap.
    localparam logic [IDX_W:0] LAST_CNT = (IDX_W+1)'(SETS - 1);

    tag_wr_state_t      state_q, state_d;
    logic [IDX_W:0]     cnt_q, cnt_d;
    logic               csb0_q, csb0_d;
    logic [IDX_W-1:0]   addr0_q, addr0_d;
    logic [ENTRY_W-1:0] din0_q, din0_d;
    logic               init_done_q, init_done_d;
    logic               byp_valid_q, byp_valid_d;
    logic [ENTRY_W-1:0] byp_data_q, byp_data_d;
    logic               accept;

    // Requests are only taken once the sweep has fully retired and no flush is pending.
    assign wr_ready = (state_q == TW_RUN) && init_done_q && !flush;
    assign accept   = wr_valid && wr_ready;

    // Next-state for the FSM, sweep counter and write-port registers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        csb0_d      = 1'b1;
        addr0_d     = addr0_q;
        din0_d      = din0_q;
        init_done_d = init_done_q;
        if (state_q == TW_INIT) begin
            init_done_d = 1'b0;
            if (flush) begin
                cnt_d = '0;
            end else begin
                csb0_d  = 1'b0;
                addr0_d = cnt_q[IDX_W-1:0];
                din0_d  = '0;
                cnt_d   = cnt_q + (IDX_W+1)'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = TW_RUN;
                end
            end
        end else begin
            if (flush) begin
                state_d     = TW_INIT;
                cnt_d       = '0;
                init_done_d = 1'b0;
            end else begin
                // First RUN cycle still shows the last sweep write; done follows it.
                init_done_d = 1'b1;
                if (accept) begin
                    csb0_d  = 1'b0;
                    addr0_d = wr_idx;
                    din0_d  = wr_inv ? '0 : {1'b1, wr_tag};
                end
            end
        end
    end

    // Bypass: a read of the set being written this cycle sees the new entry next cycle.
    always_comb begin
        byp_valid_d = 1'b0;
        byp_data_d  = byp_data_q;
        if (rd_en) begin
            if (state_q == TW_INIT) begin
                byp_valid_d = 1'b1;
                byp_data_d  = '0;
            end else if (!csb0_q && (addr0_q == rd_idx)) begin
                byp_valid_d = 1'b1;
                byp_data_d  = din0_q;
            end
        end
    end

    // State and port registers; reset drops any in-flight write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= TW_INIT;
            cnt_q       <= '0;
            csb0_q      <= 1'b1;
            addr0_q     <= '0;
            din0_q      <= '0;
            init_done_q <= 1'b0;
            byp_valid_q <= 1'b0;
            byp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            csb0_q      <= csb0_d;
            addr0_q     <= addr0_d;
            din0_q      <= din0_d;
            init_done_q <= init_done_d;
            byp_valid_q <= byp_valid_d;
            byp_data_q  <= byp_data_d;
        end
    end

    assign sram_csb0  = csb0_q;
    assign sram_addr0 = addr0_q;
    assign sram_din0  = din0_q;
    assign init_done  = init_done_q;
    assign byp_valid  = byp_valid_q;
    assign byp_data   = byp_data_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_l1_tag_writer.sv
// Self-checking bench for l1_tag_writer: write-port scoreboard plus bypass scoreboard.
module tb_l1_tag_writer;
    import core_pkg::*;

    localparam int IDX_W   = L1_IDX_W;
    localparam int ENTRY_W = L1_ENTRY_W;
    localparam int SETS    = L1_SETS;
    localparam int W       = IDX_W + ENTRY_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               wr_valid;
    logic               wr_ready;
    logic [IDX_W-1:0]   wr_idx;
    logic [ENTRY_W-2:0] wr_tag;
    logic               wr_inv;
    logic               rd_en;
    logic [IDX_W-1:0]   rd_idx;
    logic               sram_csb0;
    logic [IDX_W-1:0]   sram_addr0;
    logic [ENTRY_W-1:0] sram_din0;
    logic               init_done;
    logic               byp_valid;
    logic [ENTRY_W-1:0] byp_data;
    tag_wr_state_t      dbg_state;

    int checks = 0;
    int errors = 0;

    // Expected SRAM writes {addr, din} and expected bypass results {care_data, valid, data}.
    logic [W-1:0]         exp_q[$];
    logic [ENTRY_W+1:0]   byp_q[$];
    logic                 rd_prev = 1'b0;

    l1_tag_writer dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_idx     (wr_idx),
        .wr_tag     (wr_tag),
        .wr_inv     (wr_inv),
        .rd_en      (rd_en),
        .rd_idx     (rd_idx),
        .sram_csb0  (sram_csb0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .init_done  (init_done),
        .byp_valid  (byp_valid),
        .byp_data   (byp_data),
        .dbg_state  (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write-port monitor: every cycle with csb0 low must match the next expected write.
    always @(negedge clk) begin
        if (rst === 1'b0 && sram_csb0 === 1'b0) begin
            if (exp_q.size() == 0) begin
                check("wr_unexp", {5'b0, sram_addr0, sram_din0}, 32'hFFFF_FFFF);
            end else begin
                check("wr_port", {5'b0, sram_addr0, sram_din0}, {5'b0, exp_q.pop_front()});
            end
        end
    end

    // Bypass monitor: a read sampled at a rising edge is answered by the next falling edge.
    always @(posedge clk) rd_prev <= rd_en;

    always @(negedge clk) begin
        logic [ENTRY_W+1:0] b;
        if (rd_prev === 1'b1 && rst === 1'b0) begin
            if (byp_q.size() == 0) begin
                check("byp_unexp", 32'(byp_valid), 32'hFFFF_FFFF);
            end else begin
                b = byp_q.pop_front();
                check("byp_valid", 32'(byp_valid), 32'(b[ENTRY_W]));
                if (b[ENTRY_W+1]) check("byp_data", 32'(byp_data), 32'(b[ENTRY_W-1:0]));
            end
        end
    end

    // Driver tasks
    task automatic push_sweep();
        for (int i = 0; i < SETS; i++) begin
            exp_q.push_back({IDX_W'(i), {ENTRY_W{1'b0}}});
        end
    endtask

    task automatic wait_init(input string tag);
        logic [IDX_W-1:0] last_addr;
        logic             last_csb;
        logic             ok;
        last_addr = '0;
        last_csb  = 1'b1;
        ok        = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (init_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            check({tag, "_ready_low"}, 32'(wr_ready), 32'd0);
            last_addr = sram_addr0;
            last_csb  = sram_csb0;
        end
        check({tag, "_done"}, 32'(ok), 32'd1);
        check({tag, "_last_wr"}, {23'b0, last_csb, last_addr}, {23'b0, 1'b0, 8'hFF});
        check({tag, "_swept"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(TW_RUN));
    endtask

    task automatic send(input logic [IDX_W-1:0] idx, input logic [ENTRY_W-2:0] tag,
                        input logic inv);
        logic [ENTRY_W-1:0] d;
        wr_valid = 1'b1;
        wr_idx   = idx;
        wr_tag   = tag;
        wr_inv   = inv;
        #1;
        check("send_ready", 32'(wr_ready), 32'd1);
        d = inv ? '0 : {1'b1, tag};
        exp_q.push_back({idx, d});
        @(negedge clk);
        wr_valid = 1'b0;
        wr_inv   = 1'b0;
    endtask

    // Main sequence
    initial begin
        logic             found;
        logic             inf_v;
        logic [IDX_W-1:0] inf_a;
        logic [ENTRY_W-1:0] inf_d;
        logic             rd, acc, hit;
        logic [IDX_W-1:0] ridx, widx;
        logic [ENTRY_W-2:0] wtag;
        logic             winv;
        logic [ENTRY_W-1:0] wd;

        rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; wr_idx = '0; wr_tag = '0;
        wr_inv = 1'b0; rd_en = 1'b0; rd_idx = '0;
        repeat (3) @(negedge clk);
        check("rst_csb", 32'(sram_csb0), 32'd1);
        check("rst_addr", 32'(sram_addr0), 32'd0);
        check("rst_din", 32'(sram_din0), 32'd0);
        check("rst_done", 32'(init_done), 32'd0);
        check("rst_ready", 32'(wr_ready), 32'd0);
        check("rst_byp", {12'b0, byp_valid, byp_data}, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(TW_INIT));

        // Sweep after reset
        rst = 1'b0;
        push_sweep();
        wait_init("t1");
        check("t1_idle_csb", 32'(sram_csb0), 32'd1);

        // Single tag fill
        send(8'h2A, 18'h1_2345, 1'b0);
        check("t2_csb", 32'(sram_csb0), 32'd0);
        check("t2_addr", 32'(sram_addr0), 32'h2A);
        check("t2_din", 32'(sram_din0), 32'h5_2345);
        @(negedge clk);
        check("t2_csb_idle", 32'(sram_csb0), 32'd1);

        // Collision and non-collision reads
        send(8'd5, 18'h2_ABCD, 1'b0);
        rd_en = 1'b1; rd_idx = 8'd5;
        byp_q.push_back({1'b1, 1'b1, 1'b1, 18'h2_ABCD});
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        send(8'd5, 18'h0_1111, 1'b0);
        rd_en = 1'b1; rd_idx = 8'd6;
        byp_q.push_back({1'b0, 1'b0, {ENTRY_W{1'b0}}});
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);

        // Flush with a simultaneous request, then a read during the sweep
        flush = 1'b1; wr_valid = 1'b1; wr_idx = 8'h77; wr_tag = 18'h3_FFFF;
        #1;
        check("t4_ready", 32'(wr_ready), 32'd0);
        push_sweep();
        @(negedge clk);
        flush = 1'b0; wr_valid = 1'b0;
        check("t4_done_low", 32'(init_done), 32'd0);
        rd_en = 1'b1; rd_idx = 8'h33;
        byp_q.push_back({1'b1, 1'b1, {ENTRY_W{1'b0}}});
        @(negedge clk);
        rd_en = 1'b0;
        wait_init("t4");

        // Reset in the middle of a sweep
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_sweep();
        found = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (sram_csb0 === 1'b0 && sram_addr0 === 8'd99) begin
                found = 1'b1;
                break;
            end
        end
        check("t5_reach", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_csb_async", 32'(sram_csb0), 32'd1);
        check("t5_addr_async", 32'(sram_addr0), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_sweep();
        wait_init("t5");

        // Fill then invalidate the same set back to back, with colliding reads
        send(8'd9, 18'h3_C0DE, 1'b0);
        rd_en = 1'b1; rd_idx = 8'd9;
        byp_q.push_back({1'b1, 1'b1, 1'b1, 18'h3_C0DE});
        send(8'd9, 18'h1_5555, 1'b1);
        check("t6_din_inv", 32'(sram_din0), 32'd0);
        byp_q.push_back({1'b1, 1'b1, {ENTRY_W{1'b0}}});
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);

        // Randomised fills/invalidates with reads aimed at the in-flight set
        inf_v = 1'b0; inf_a = '0; inf_d = '0;
        for (int i = 0; i < 32; i++) begin
            rd   = 1'($urandom_range(0, 1));
            ridx = IDX_W'($urandom_range(0, 3));
            acc  = ($urandom_range(0, 2) != 0);
            widx = IDX_W'($urandom_range(0, 3));
            wtag = ENTRY_W'($urandom_range(0, 32'h3_FFFF));
            winv = ($urandom_range(0, 3) == 0);
            if (rd) begin
                hit = inf_v && (inf_a == ridx);
                byp_q.push_back({hit, hit, hit ? inf_d : {ENTRY_W{1'b0}}});
            end
            rd_en = rd; rd_idx = ridx;
            wr_valid = acc; wr_idx = widx; wr_tag = wtag; wr_inv = winv;
            wd = winv ? '0 : {1'b1, wtag};
            if (acc) begin
                #1;
                check("rnd_ready", 32'(wr_ready), 32'd1);
                exp_q.push_back({widx, wd});
            end
            inf_v = acc; inf_a = widx; inf_d = wd;
            @(negedge clk);
        end
        wr_valid = 1'b0; rd_en = 1'b0;
        repeat (2) @(negedge clk);

        check("end_wr_q", 32'(exp_q.size()), 32'd0);
        check("end_byp_q", 32'(byp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
